// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: interrupt/commit inputs, CSR write strobes and the fetch redirect handshake.
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            interrupt;
    logic [4:0]      int_code;
    logic [XLEN-1:0] pc_addr;
    logic            exc_valid;
    logic [4:0]      exc_code;
    logic            mret;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            pipe_empty;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] mepc_q;
    logic            redirect_ready;

    logic            stall_fetch;
    logic            flush;
    logic            csr_we_mepc;
    logic [XLEN-1:0] mepc_wdata;
    logic            csr_we_mcause;
    logic [XLEN-1:0] mcause_wdata;
    logic            csr_trap_mstatus;
    logic            csr_mret_mstatus;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    modport master (
        input  interrupt, int_code, pc_addr, exc_valid, exc_code, mret,
               commit_valid, commit_pc, pipe_empty, next_pc, mepc_q, redirect_ready,
        output stall_fetch, flush, csr_we_mepc, mepc_wdata, csr_we_mcause, mcause_wdata,
               csr_trap_mstatus, csr_mret_mstatus, redirect_valid, redirect_pc, busy
    );

    modport slave (
        output interrupt, int_code, pc_addr, exc_valid, exc_code, mret,
               commit_valid, commit_pc, pipe_empty, next_pc, mepc_q, redirect_ready,
        input  stall_fetch, flush, csr_we_mepc, mepc_wdata, csr_we_mcause, mcause_wdata,
               csr_trap_mstatus, csr_mret_mstatus, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: drain or flush the pipe, write mepc/mcause/mstatus,
// then hold a fetch redirect until it is accepted.
module trap_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              reset,
    trap_sequencer_if.master bus
);
    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WRITE,
        ST_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            is_mret_q, is_mret_d;
    logic            first_q, first_d;

    // Cause layout: interrupt flag in the MSB, code in the low bits, zeros between.
    function automatic logic [XLEN-1:0] mk_cause(input logic irq, input logic [CODE_W-1:0] code);
        logic [XLEN-1:0] c;
        c               = '0;
        c[XLEN-1]       = irq;
        c[CODE_W-1:0]   = code;
        return c;
    endfunction

    assign bus.busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            tgt_q     <= '0;
            is_mret_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            tgt_q     <= tgt_d;
            is_mret_q <= is_mret_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        epc_d                 = epc_q;
        cause_d               = cause_q;
        tgt_d                 = tgt_q;
        is_mret_d             = is_mret_q;
        first_d               = 1'b0;
        bus.stall_fetch       = 1'b0;
        bus.flush             = 1'b0;
        bus.csr_we_mepc       = 1'b0;
        bus.mepc_wdata        = '0;
        bus.csr_we_mcause     = 1'b0;
        bus.mcause_wdata      = '0;
        bus.csr_trap_mstatus  = 1'b0;
        bus.csr_mret_mstatus  = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.exc_valid && bus.commit_valid) begin
                    epc_d     = bus.commit_pc;
                    cause_d   = mk_cause(1'b0, bus.exc_code);
                    bus.flush = 1'b1;
                    state_d   = ST_WRITE;
                end else if (bus.interrupt) begin
                    if (bus.commit_valid) begin
                        epc_d     = bus.commit_pc;
                        cause_d   = mk_cause(1'b1, bus.int_code);
                        bus.flush = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        state_d   = ST_DRAIN;
                    end
                end else if (bus.mret && bus.commit_valid) begin
                    is_mret_d = 1'b1;
                    tgt_d     = bus.mepc_q;
                    bus.flush = 1'b1;
                    first_d   = 1'b1;
                    state_d   = ST_REDIRECT;
                end
            end

            // Wait for a commit point or an empty pipe; the interrupt may withdraw meanwhile.
            ST_DRAIN: begin
                bus.stall_fetch = 1'b1;
                if (bus.exc_valid && bus.commit_valid) begin
                    epc_d     = bus.commit_pc;
                    cause_d   = mk_cause(1'b0, bus.exc_code);
                    bus.flush = 1'b1;
                    state_d   = ST_WRITE;
                end else if (!bus.interrupt) begin
                    state_d   = ST_IDLE;
                end else if (bus.commit_valid) begin
                    epc_d     = bus.commit_pc;
                    cause_d   = mk_cause(1'b1, bus.int_code);
                    bus.flush = 1'b1;
                    state_d   = ST_WRITE;
                end else if (bus.pipe_empty) begin
                    epc_d     = bus.next_pc;
                    cause_d   = mk_cause(1'b1, bus.int_code);
                    bus.flush = 1'b1;
                    state_d   = ST_WRITE;
                end
            end

            ST_WRITE: begin
                bus.csr_we_mepc      = 1'b1;
                bus.mepc_wdata       = epc_q;
                bus.csr_we_mcause    = 1'b1;
                bus.mcause_wdata     = cause_q;
                bus.csr_trap_mstatus = 1'b1;
                bus.flush            = 1'b1;
                bus.stall_fetch      = 1'b1;
                is_mret_d            = 1'b0;
                first_d              = 1'b1;
                state_d              = ST_REDIRECT;
            end

            // pc_addr is taken on the first cycle and then held in tgt_q so the target cannot move.
            ST_REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.stall_fetch    = 1'b1;
                if (first_q && !is_mret_q) begin
                    bus.redirect_pc = bus.pc_addr;
                    tgt_d           = bus.pc_addr;
                end else begin
                    bus.redirect_pc = tgt_q;
                end
                bus.csr_mret_mstatus = first_q && is_mret_q;
                if (bus.redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized episode-level bench for trap_sequencer with a small mtvec/mcause CSR model.
module tb_trap_sequencer;
    localparam int unsigned XLEN = 32;
    localparam int unsigned END_COMMIT = 0;
    localparam int unsigned END_EMPTY  = 1;
    localparam int unsigned END_ABORT  = 2;
    localparam int unsigned END_EXC    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_sequencer_if #(.XLEN(XLEN)) bus ();
    trap_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset(rst), .bus(bus));

    typedef struct {
        logic        stall, flush, we_mepc, we_mcause, trap_ms, mret_ms, rv, busy;
        logic [31:0] mepc_wd, mcause_wd, rpc;
    } exp_t;

    exp_t        e;
    logic [31:0] mtvec_m, mcause_m;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Environment CSR block: direct mode jumps to base, vectored interrupts to base + 4*code.
    function automatic logic [31:0] vec_pc(input logic [31:0] tv, input logic [31:0] mc);
        logic [31:0] base;
        base = {tv[31:2], 2'b00};
        if (tv[1:0] == 2'b01 && mc[31]) return base + 32'(mc[4:0]) * 32'd4;
        return base;
    endfunction

    assign bus.pc_addr = vec_pc(mtvec_m, mcause_m);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic clr();
        e.stall = 0; e.flush = 0; e.we_mepc = 0; e.we_mcause = 0; e.trap_ms = 0;
        e.mret_ms = 0; e.rv = 0; e.busy = 0;
        e.mepc_wd = '0; e.mcause_wd = '0; e.rpc = '0;
    endtask

    // Idle-looking inputs: no interrupt or commit, but stray exc/mret/ready that must be ignored.
    task automatic quiet();
        bus.interrupt      = 1'b0;
        bus.commit_valid   = 1'b0;
        bus.exc_valid      = 1'($urandom);
        bus.mret           = 1'($urandom);
        bus.pipe_empty     = 1'($urandom);
        bus.redirect_ready = 1'($urandom);
        bus.int_code       = 5'($urandom);
        bus.exc_code       = 5'($urandom);
        bus.commit_pc      = $urandom;
        bus.next_pc        = $urandom;
        bus.mepc_q         = $urandom;
    endtask

    task automatic noise();
        quiet();
        bus.interrupt    = 1'($urandom);
        bus.commit_valid = 1'($urandom);
    endtask

    task automatic tick(input string ph);
        #1;
        check({ph, ".stall"},  64'(bus.stall_fetch),      64'(e.stall));
        check({ph, ".flush"},  64'(bus.flush),            64'(e.flush));
        check({ph, ".we_epc"}, 64'(bus.csr_we_mepc),      64'(e.we_mepc));
        check({ph, ".epc"},    64'(bus.mepc_wdata),       64'(e.mepc_wd));
        check({ph, ".we_cau"}, 64'(bus.csr_we_mcause),    64'(e.we_mcause));
        check({ph, ".cause"},  64'(bus.mcause_wdata),     64'(e.mcause_wd));
        check({ph, ".trapst"}, 64'(bus.csr_trap_mstatus), 64'(e.trap_ms));
        check({ph, ".mretst"}, 64'(bus.csr_mret_mstatus), 64'(e.mret_ms));
        check({ph, ".rvalid"}, 64'(bus.redirect_valid),   64'(e.rv));
        check({ph, ".rpc"},    64'(bus.redirect_pc),      64'(e.rpc));
        check({ph, ".busy"},   64'(bus.busy),             64'(e.busy));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect_wait(input logic [31:0] tgt, input logic is_mret, input int unsigned nwait);
        for (int i = 0; i <= int'(nwait); i++) begin
            noise();
            bus.redirect_ready = (i == int'(nwait));
            clr();
            e.rv = 1; e.rpc = tgt; e.stall = 1; e.busy = 1;
            e.mret_ms = is_mret && (i == 0);
            tick("redir");
        end
        quiet();
        clr();
        tick("back_idle");
    endtask

    task automatic write_phase(input logic [31:0] epc, input logic [31:0] cause);
        noise();
        clr();
        e.we_mepc = 1; e.mepc_wd = epc; e.we_mcause = 1; e.mcause_wd = cause;
        e.trap_ms = 1; e.flush = 1; e.stall = 1; e.busy = 1;
        tick("write");
        mcause_m = cause;
    endtask

    task automatic finish_trap(input logic [31:0] epc, input logic [31:0] cause, input int unsigned nwait);
        write_phase(epc, cause);
        redirect_wait(vec_pc(mtvec_m, cause), 1'b0, nwait);
    endtask

    task automatic run_exc(input logic [4:0] code, input logic [31:0] pc, input logic others,
                           input int unsigned nwait);
        quiet();
        bus.exc_valid = 1; bus.commit_valid = 1; bus.exc_code = code; bus.commit_pc = pc;
        bus.interrupt = others; bus.mret = others;
        clr();
        e.flush = 1;
        tick("exc");
        finish_trap(pc, 32'(code), nwait);
    endtask

    // k = cycles with interrupt up and nothing committing before the capture cycle.
    task automatic run_irq(input int unsigned k, input int unsigned ending, input logic [4:0] code,
                           input logic [31:0] pc, input int unsigned nwait);
        logic [31:0] cause;
        cause = (ending == END_EXC) ? 32'(code) : (32'h8000_0000 | 32'(code));
        if (k == 0) begin
            quiet();
            bus.interrupt = 1; bus.commit_valid = 1; bus.exc_valid = 0;
            bus.int_code = code; bus.commit_pc = pc;
            clr();
            e.flush = 1;
            tick("irq_cap0");
            finish_trap(pc, cause, nwait);
            return;
        end
        quiet();
        bus.interrupt = 1;
        clr();
        tick("irq_enter");
        for (int i = 1; i < int'(k); i++) begin
            quiet();
            bus.interrupt = 1; bus.pipe_empty = 0;
            clr();
            e.stall = 1; e.busy = 1;
            tick("drain");
        end
        quiet();
        clr();
        e.stall = 1; e.busy = 1;
        case (ending)
            END_COMMIT: begin
                bus.interrupt = 1; bus.exc_valid = 0; bus.commit_valid = 1;
                bus.int_code = code; bus.commit_pc = pc;
            end
            END_EMPTY: begin
                bus.interrupt = 1; bus.pipe_empty = 1; bus.int_code = code; bus.next_pc = pc;
            end
            END_EXC: begin
                bus.interrupt = 1'($urandom); bus.exc_valid = 1; bus.commit_valid = 1;
                bus.exc_code = code; bus.commit_pc = pc;
            end
            default: begin
                bus.interrupt = 0; bus.exc_valid = 0;
            end
        endcase
        if (ending == END_ABORT) begin
            tick("abort");
            quiet();
            clr();
            tick("abort_idle");
        end else begin
            e.flush = 1;
            tick("drain_cap");
            finish_trap(pc, cause, nwait);
        end
    endtask

    task automatic run_mret(input logic [31:0] tgt, input int unsigned nwait);
        quiet();
        bus.mret = 1; bus.commit_valid = 1; bus.exc_valid = 0; bus.mepc_q = tgt;
        clr();
        e.flush = 1;
        tick("mret");
        redirect_wait(tgt, 1'b1, nwait);
    endtask

    task automatic run_reset_mid();
        logic [31:0] pc;
        logic [4:0]  code;
        pc   = $urandom;
        code = 5'($urandom);
        quiet();
        bus.exc_valid = 1; bus.commit_valid = 1; bus.exc_code = code; bus.commit_pc = pc;
        clr();
        e.flush = 1;
        tick("rst_exc");
        write_phase(pc, 32'(code));
        noise();
        bus.redirect_ready = 0;
        clr();
        e.rv = 1; e.rpc = vec_pc(mtvec_m, 32'(code)); e.stall = 1; e.busy = 1;
        tick("rst_redir");
        noise();
        bus.redirect_ready = 0;
        rst = 1;
        e.rv = 1; e.stall = 1; e.busy = 1;
        tick("rst_cycle");
        rst = 0;
        quiet();
        clr();
        tick("post_rst");
        run_exc(5'($urandom), $urandom, 1'b0, 1);
    endtask

    initial begin
        rst      = 1;
        mtvec_m  = 32'h80;
        mcause_m = '0;
        quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr();
        tick("reset");
        rst = 0;

        mtvec_m = 32'h80;
        run_exc(5'd2, 32'h100, 1'b0, 2);
        mtvec_m = 32'h81;
        run_irq(3, END_COMMIT, 5'd7, 32'h200, 0);
        run_irq(1, END_EMPTY, 5'd3, 32'h344, 1);
        run_exc(5'd11, 32'h4000, 1'b1, 0);
        run_irq(2, END_ABORT, 5'd5, 32'h0, 0);
        run_mret(32'h1234, 2);
        run_reset_mid();

        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            mtvec_m = {$urandom_range(32'h0FFF_FFFF, 0), 2'b00} | 32'($urandom_range(1, 0));
            kind    = $urandom_range(4, 0);
            case (kind)
                0: run_exc(5'($urandom), $urandom, 1'($urandom), $urandom_range(3, 0));
                1: run_irq($urandom_range(4, 0), $urandom_range(3, 0), 5'($urandom), $urandom,
                           $urandom_range(3, 0));
                2: run_mret($urandom, $urandom_range(3, 0));
                3: run_reset_mid();
                default: begin
                    quiet();
                    clr();
                    tick("idle");
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Downstream consumer of the interrupt-control block.
- Takes its `interrupt`, `int_code` and `pc_addr` outputs, plus synchronous exceptions and `mret` from the commit stage.
- Sequences trap entry and return in four phases: drain/flush the pipeline, write `mepc`/`mcause`/`mstatus`, redirect fetch, handshake the redirect.
- Sits between the CSR block and the fetch/commit control.

Parameters:
- XLEN, 32, datapath/CSR width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- interrupt  in  1  pending-and-enabled interrupt from interrupt control
- int_code  in  5  interrupt cause code
- pc_addr  in  XLEN  trap vector target; combinationally derived from the current mtvec/mcause CSRs
- exc_valid  in  1  synchronous exception on the committing instruction
- exc_code  in  5  exception cause code
- mret  in  1  committing instruction is MRET
- commit_valid  in  1  an instruction is at the commit point this cycle
- commit_pc  in  XLEN  PC of the committing instruction
- pipe_empty  in  1  no instruction in flight
- next_pc  in  XLEN  fetch PC, used as epc when the pipe is empty
- mepc_q  in  XLEN  current mepc CSR value
- redirect_ready  in  1  fetch accepts the redirect
- stall_fetch  out  1  hold fetch
- flush  out  1  kill all in-flight instructions
- csr_we_mepc  out  1  mepc write strobe
- mepc_wdata  out  XLEN  mepc write data
- csr_we_mcause  out  1  mcause write strobe
- mcause_wdata  out  XLEN  mcause write data
- csr_trap_mstatus  out  1  trap-entry strobe: MPIE<=MIE, MIE<=0
- csr_mret_mstatus  out  1  return strobe: MIE<=MPIE, MPIE<=1
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  redirect target
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal epc/cause/target registers cleared.
- Reset has priority over every other event, including mid-sequence; a partially written trap is abandoned.
- States: IDLE, DRAIN, WRITE, REDIRECT.
- Internal registers: epc_r, cause_r, is_mret_r, tgt_r.

IDLE (priority exc_valid&commit_valid > interrupt > mret&commit_valid):
- Exception: epc_r<=commit_pc; cause_r<={1'b0,(XLEN-6)'b0,exc_code}; flush=1 this cycle; go to WRITE.
- Interrupt with commit_valid: same capture, but cause_r<={1'b1,(XLEN-6)'b0,int_code}; the committing instruction is killed, not retired; flush=1; go to WRITE.
- Interrupt without commit_valid: go to DRAIN.
- MRET: is_mret_r<=1; tgt_r<=mepc_q; flush=1; go to REDIRECT.

DRAIN:
- stall_fetch=1 held.
- Exception with commit_valid: exception path as in IDLE (exception wins).
- Else commit_valid: capture commit_pc with the interrupt cause; go to WRITE.
- Else pipe_empty: epc_r<=next_pc with the interrupt cause; go to WRITE.
- interrupt deasserting while in DRAIN (and no exception) aborts: go to IDLE; stall releases the next cycle.
- int_code is sampled in the capture cycle, not on entry to DRAIN.

WRITE (exactly 1 cycle):
- csr_we_mepc=1, mepc_wdata=epc_r.
- csr_we_mcause=1, mcause_wdata=cause_r.
- csr_trap_mstatus=1.
- flush=1, stall_fetch=1.
- is_mret_r<=0; go to REDIRECT.

REDIRECT:
- redirect_valid=1; stall_fetch=1.
- redirect_pc = is_mret_r ? tgt_r : pc_addr. pc_addr is sampled here, one cycle after the mcause write, so vectored mode sees the new cause.
- On entry from IDLE via MRET: csr_mret_mstatus=1 for the first REDIRECT cycle only.
- redirect_valid and redirect_pc stay stable until redirect_ready.
- When redirect_valid&redirect_ready: go to IDLE.
- interrupt, exc_valid and mret are ignored while in WRITE or REDIRECT.

Timing and widths:
- busy = (state!=IDLE).
- Latency from an exception in IDLE to redirect_valid: 2 cycles.
- All strobes are single-cycle pulses.
- Cause encoding: bit XLEN-1 is the interrupt flag, bits [4:0] are the code, all other bits are 0.

Test Plan:
- Exception in IDLE: exc_valid=1, exc_code=2, commit_valid=1, commit_pc=0x100, mtvec=0x80 direct. Required: flush in cycle 0; WRITE in cycle 1 with mepc_wdata=0x100, mcause_wdata=0x00000002, csr_trap_mstatus=1; redirect_valid=1 with redirect_pc=0x80 from cycle 2; redirect_ready=1 in cycle 4 gives busy=0 in cycle 5.
- Interrupt via DRAIN, vectored mode: interrupt=1, int_code=7, pipe busy with commit_valid=0 for 3 cycles, then commit_pc=0x200. Required: stall_fetch high for those 3 cycles; mcause_wdata=0x80000007, mepc_wdata=0x200; with mtvec=0x81 (vectored, base 0x80), redirect_pc=0x9C.
- Empty-pipe interrupt: interrupt=1, pipe_empty=1, next_pc=0x344, int_code=3. Required: mepc_wdata=0x344, mcause_wdata=0x80000003.
- Simultaneous events: exc_valid, interrupt and mret all high with commit_valid. Required: exception cause only; csr_mret_mstatus stays 0. Separately, interrupt drops during DRAIN: FSM returns to IDLE with no CSR strobes.
- MRET: mret=1, commit_valid=1, mepc_q=0x1234. Required: flush=1; csr_mret_mstatus pulses once; redirect_pc=0x1234; no mepc/mcause writes.
- Reset mid-operation: reset asserted during REDIRECT with redirect_ready=0. Required: next cycle all outputs 0, busy=0, and a fresh exception is handled normally.
